// File: rtl/dense_layer_output_collector_if.sv
// dense_layer_output_collector_if
// Issue, lane-result and realigned-output signals of the dense-layer output
// collector. The backprop control fields exist only when
// DENSE_COLLECTOR_BACKPROP_EN is defined.
interface dense_layer_output_collector_if #(
   parameter int size                   = 3,
   parameter int data_size              = 16,
   parameter int act_type_size          = 4,
   parameter int cost_type_size         = 8,
   parameter int dense_type_size        = 4,
   parameter int backprop_controll_size = 66
);
   logic                          in_valid;
   logic                          in_ready;
   logic [act_type_size-1:0]      act_type;
   logic [cost_type_size-1:0]     cost_type;
   logic [dense_type_size-1:0]    dense_type;
   logic [data_size*size-1:0]     predict_value;
`ifdef DENSE_COLLECTOR_BACKPROP_EN
   logic [backprop_controll_size-1:0] backprop_controll;
   logic [backprop_controll_size-1:0] backprop_controll_out;
`endif
   logic [data_size*size-1:0]     y;
   logic [size-1:0]               y_valid;
   logic                          out_valid;
   logic                          out_ready;
   logic [data_size*size-1:0]     x_out;
   logic [act_type_size-1:0]      act_type_out;
   logic [cost_type_size-1:0]     cost_type_out;
   logic [dense_type_size-1:0]    dense_type_out;
   logic [data_size*size-1:0]     predict_value_out;
   logic                          overflow;

   // Environment side: issues vectors, supplies lane results, consumes output.
   modport master (
      output in_valid, act_type, cost_type, dense_type, predict_value,
`ifdef DENSE_COLLECTOR_BACKPROP_EN
      output backprop_controll,
      input  backprop_controll_out,
`endif
      output y, y_valid, out_ready,
      input  in_ready, out_valid, x_out, act_type_out, cost_type_out,
      input  dense_type_out, predict_value_out, overflow
   );

   // Collector side.
   modport slave (
      input  in_valid, act_type, cost_type, dense_type, predict_value,
`ifdef DENSE_COLLECTOR_BACKPROP_EN
      input  backprop_controll,
      output backprop_controll_out,
`endif
      input  y, y_valid, out_ready,
      output in_ready, out_valid, x_out, act_type_out, cost_type_out,
      output dense_type_out, predict_value_out, overflow
   );
endinterface

// File: rtl/dense_layer_output_collector.sv
// dense_layer_output_collector
// Buffers the control fields of each issued vector and the skewed per-lane
// results of the dense array, then emits every completed vector realigned
// with its own control fields on a valid/ready output, in issue order.
// Optional feature: DENSE_COLLECTOR_BACKPROP_EN carries backprop_controll
// through the control FIFO.
module dense_layer_output_collector #(
   parameter int size                   = 3,
   parameter int data_size              = 16,
   parameter int act_type_size          = 4,
   parameter int cost_type_size         = 8,
   parameter int dense_type_size        = 4,
   parameter int backprop_controll_size = 66,
   parameter int fifo_depth             = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   dense_layer_output_collector_if.slave bus
);
   localparam int aw = $clog2(fifo_depth);
   localparam int pw = data_size * size;
`ifdef DENSE_COLLECTOR_BACKPROP_EN
   localparam int cw = act_type_size + cost_type_size + dense_type_size + pw
                       + backprop_controll_size;
`else
   localparam int cw = act_type_size + cost_type_size + dense_type_size + pw;
`endif
   localparam logic [aw:0] full_cnt = (aw+1)'(fifo_depth);

   if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 ||
       backprop_controll_size < 1) begin : g_bad_cfg
      $error("dense_layer_output_collector: illegal parameter set");
   end

   logic                 issue_fire;
   logic                 out_fire;
   logic                 load;
   logic [aw:0]          outstanding;

   logic [cw-1:0]        ctrl_mem [fifo_depth];
   logic [aw-1:0]        ctrl_wptr;
   logic [aw-1:0]        ctrl_rptr;
   logic [aw:0]          ctrl_cnt;
   logic [cw-1:0]        ctrl_in;
   logic [cw-1:0]        ctrl_q;

   logic [size-1:0]      lane_nonempty;
   logic [size-1:0]      lane_ovf;
   logic [data_size-1:0] lane_head [size];

   assign bus.in_ready = (outstanding < full_cnt);
   assign issue_fire   = bus.in_valid && bus.in_ready;
   assign out_fire     = bus.out_valid && bus.out_ready;
   assign load         = (ctrl_cnt != '0) && (&lane_nonempty) &&
                         (!bus.out_valid || bus.out_ready);

`ifdef DENSE_COLLECTOR_BACKPROP_EN
   assign ctrl_in = {bus.act_type, bus.cost_type, bus.dense_type,
                     bus.predict_value, bus.backprop_controll};
   assign {bus.act_type_out, bus.cost_type_out, bus.dense_type_out,
           bus.predict_value_out, bus.backprop_controll_out} = ctrl_q;
`else
   assign ctrl_in = {bus.act_type, bus.cost_type, bus.dense_type,
                     bus.predict_value};
   assign {bus.act_type_out, bus.cost_type_out, bus.dense_type_out,
           bus.predict_value_out} = ctrl_q;
`endif

   // Vectors issued but not yet handed downstream; gates further issues.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else if (issue_fire && !out_fire) begin
         outstanding <= outstanding + (aw+1)'(1);
      end else if (!issue_fire && out_fire) begin
         outstanding <= outstanding - (aw+1)'(1);
      end
   end

   // Control FIFO storage; never full because issues are bounded by outstanding.
   always_ff @(posedge clk) begin
      if (issue_fire) begin
         ctrl_mem[ctrl_wptr] <= ctrl_in;
      end
   end

   // Control FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_wptr <= '0;
         ctrl_rptr <= '0;
         ctrl_cnt  <= '0;
      end else begin
         if (issue_fire) ctrl_wptr <= ctrl_wptr + aw'(1);
         if (load)       ctrl_rptr <= ctrl_rptr + aw'(1);
         if (issue_fire && !load) begin
            ctrl_cnt <= ctrl_cnt + (aw+1)'(1);
         end else if (!issue_fire && load) begin
            ctrl_cnt <= ctrl_cnt - (aw+1)'(1);
         end
      end
   end

   for (genvar g = 0; g < size; g++) begin : g_lane
      logic [data_size-1:0] mem [fifo_depth];
      logic [aw-1:0]        wptr;
      logic [aw-1:0]        rptr;
      logic [aw:0]          cnt;
      logic                 full;
      logic                 push;

      // A full lane still accepts a result when the same edge pops it.
      assign full              = (cnt == full_cnt);
      assign push              = bus.y_valid[g] && (!full || load);
      assign lane_ovf[g]       = bus.y_valid[g] && full && !load;
      assign lane_nonempty[g]  = (cnt != '0);
      assign lane_head[g]      = mem[rptr];

      // Lane result storage.
      always_ff @(posedge clk) begin
         if (push) begin
            mem[wptr] <= bus.y[g*data_size +: data_size];
         end
      end

      // Lane FIFO pointers and occupancy; all lanes pop together on load.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
         end else begin
            if (push) wptr <= wptr + aw'(1);
            if (load) rptr <= rptr + aw'(1);
            if (push && !load) begin
               cnt <= cnt + (aw+1)'(1);
            end else if (!push && load) begin
               cnt <= cnt - (aw+1)'(1);
            end
         end
      end
   end

   // Output register: captures aligned lane heads and control head on load,
   // holds until accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.x_out     <= '0;
         ctrl_q        <= '0;
      end else if (load) begin
         bus.out_valid <= 1'b1;
         for (int unsigned i = 0; i < size; i++) begin
            bus.x_out[i*data_size +: data_size] <= lane_head[i];
         end
         ctrl_q <= ctrl_mem[ctrl_rptr];
      end else if (out_fire) begin
         bus.out_valid <= 1'b0;
      end
   end

   // Sticky protocol error: a lane result arrived with nowhere to go.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.overflow <= 1'b0;
      end else if (|lane_ovf) begin
         bus.overflow <= 1'b1;
      end
   end
endmodule
